// File: rtl/if_prefetch_stage_pkg.sv
// if_prefetch_stage_pkg: shared fetch FSM states and instruction stride
package if_prefetch_stage_pkg;
  typedef enum logic {RUN, FLUSH} state_e;
  localparam int unsigned INSTR_INC = 4;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: prefetch buffer of {pc, instruction} entries with synchronous flush
module if_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [W-1:0]                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: in-order instruction prefetcher with branch redirect and flush
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               DEPTH    = 4,
  parameter int               MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              Instr_Valid,
  output logic [DATA_W-1:0] Instruction,
  output logic [ADDR_W-1:0] PC
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = ADDR_W + DATA_W;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUT);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INSTR_INC);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, rsp_addr;
  logic [CW-1:0]     out_q, out_d, drop_q, drop_d, count;
  logic [W-1:0]      head;
  logic              fire, push, pop;
  assign fire = imem_req & imem_gnt;
  assign pop  = Instr_Valid & ~freeze & ~Branch_Taken;
  assign push = imem_rvalid & (drop_q == '0) & ~Branch_Taken;
  // with nothing to drop, in-flight requests are the contiguous words just below pc_q
  assign rsp_addr    = pc_q - ADDR_W'(out_q) * INC;
  assign imem_req    = rst & (state_q == RUN) & (({1'b0, count} + {1'b0, out_q}) < DEPTH_C) & (out_q < MAXO_C);
  assign imem_addr   = pc_q;
  assign Instr_Valid = count != '0;
  assign Instruction = Instr_Valid ? head[DATA_W-1:0] : '0;
  assign PC          = Instr_Valid ? head[W-1:DATA_W] : '0;
  always_comb begin
    out_d   = out_q + CW'(fire) - CW'(imem_rvalid);
    drop_d  = Branch_Taken ? out_d : drop_q - CW'(imem_rvalid && drop_q != '0);
    pc_d    = Branch_Taken ? (Branch_Address & ~ADDR_W'(3)) : fire ? pc_q + INC : pc_q;
    state_d = (drop_d == '0) ? RUN : Branch_Taken ? FLUSH : state_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end
  if_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (push),
    .data_i ({rsp_addr + INC, imem_rdata}),
    .pop_i  (pop),
    .flush_i(Branch_Taken),
    .data_o (head),
    .count_o(count)
  );
endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage: randomized memory/consumer driver with epoch-based reference model and scoreboard
module tb_if_prefetch_stage;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  logic clk = 0, rst = 0, freeze = 0, Branch_Taken = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] Branch_Address = 0, imem_rdata = 0;
  logic imem_req, Instr_Valid;
  logic [31:0] imem_addr, Instruction, PC;
  always #5 clk = ~clk;
  if_prefetch_stage #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .Instr_Valid(Instr_Valid), .Instruction(Instruction), .PC(PC)
  );
  typedef struct {logic [31:0] addr; int ep; int cyc;} req_t;
  req_t outs[$];
  logic [63:0] exp_q[$];
  logic [31:0] pc_m = RST_PC;
  int ep = 0, cyc = 0, pushed_now = 0, vectors = 0, miscompares = 0;
  int p_gnt = 100, p_rv = 100, p_fr = 0, p_br = 0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // One cycle: drive memory/consumer inputs, check the request rule, advance the model
  task automatic step(input bit fb = 0, input logic [31:0] fa = 0);
    int drops;
    bit exp_req;
    req_t o;
    @(posedge clk);
    #1;
    freeze = $urandom_range(99) < p_fr;
    Branch_Taken = fb || ($urandom_range(99) < p_br);
    Branch_Address = fb ? fa : $urandom;
    imem_gnt = $urandom_range(99) < p_gnt;
    imem_rvalid = outs.size() > 0 && outs[0].cyc < cyc && $urandom_range(99) < p_rv;
    imem_rdata = imem_rvalid ? word(outs[0].addr) : $urandom;
    drops = 0;
    foreach (outs[i]) if (outs[i].ep != ep) drops++;
    exp_req = drops == 0 && outs.size() < MAX_OUT && exp_q.size() + outs.size() < DEPTH;
    check("imem_req", imem_req, exp_req);
    pushed_now = 0;
    if (imem_rvalid) begin
      o = outs.pop_front();
      if (o.ep == ep && !Branch_Taken) begin
        exp_q.push_back({o.addr + 32'd4, word(o.addr)});
        pushed_now = 1;
      end
    end
    if (imem_req && imem_gnt) begin
      check("imem_addr", imem_addr, pc_m);
      outs.push_back('{pc_m, ep, cyc});
      pc_m += 4;
    end
    if (Branch_Taken) begin
      ep++;
      pc_m = Branch_Address & ~32'd3;
    end
    cyc++;
  endtask
  task automatic do_reset();
    rst = 0;
    freeze = 0;
    Branch_Taken = 0;
    imem_gnt = 0;
    imem_rvalid = 0;
    #1;
    check("rst_valid", Instr_Valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_instr", Instruction, 0);
    check("rst_pc", PC, 0);
    outs.delete();
    exp_q.delete();
    pc_m = RST_PC;
    ep = 0;
    pushed_now = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1;
  endtask
  // Monitor: consumer-side scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      check("instr_valid", Instr_Valid, exp_q.size() > pushed_now);
      if (Instr_Valid && !freeze && !Branch_Taken && exp_q.size() > pushed_now) begin
        e = exp_q.pop_front();
        check("pc", PC, e[63:32]);
        check("instruction", Instruction, e[31:0]);
      end
      if (Branch_Taken) exp_q.delete();
    end
  end
  initial begin
    int n;
    do_reset();
    repeat (30) step();
    p_fr = 100;
    repeat (10) step();
    p_fr = 0;
    repeat (10) step();
    p_rv = 0;
    n = 0;
    while (outs.size() < 2 && n < 20) begin
      step();
      n++;
    end
    check("two_outstanding", outs.size(), 2);
    step(1, 32'h103);
    p_rv = 100;
    repeat (20) step();
    p_fr = 100;
    repeat (3) step();
    p_fr = 0;
    step(1, $urandom);
    repeat (10) step();
    p_gnt = 70;
    p_rv = 60;
    p_fr = 30;
    p_br = 5;
    repeat (3000) step();
    p_gnt = 100;
    p_rv = 100;
    p_fr = 0;
    p_br = 0;
    repeat (7) step();
    do_reset();
    p_gnt = 70;
    p_rv = 60;
    p_fr = 30;
    p_br = 5;
    repeat (500) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
